// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the 6502 / DMA time-slot bus arbiter.
// Used by bus_arb_slot_timer and bus_slot_arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int BURST_CNT_W = 8;

    // Width of the access-cycle countdown, never narrower than one bit.
    function automatic int wait_cnt_w(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/bus_arb_slot_timer.sv
// Access-phase countdown: loaded with WAIT when a slot is about to start,
// o_last is high on the final access cycle of the slot.
module bus_arb_slot_timer
    import bus_arb_pkg::*;
#(
    parameter int WAIT  = 1,
    parameter int CNT_W = wait_cnt_w(WAIT)
)(
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/bus_slot_arbiter.sv
// Time-slot arbiter sharing one memory port between the 6502 core and a DMA requester.
// Define ARB_DMA_BURST_EN to let DMA hold the bus for up to DMA_BURST consecutive slots.
module bus_slot_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int WAIT      = 1,
    parameter int DMA_BURST = 4
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_in,
    output logic              cpu_ce,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              grant_dma,
    output state_t            o_dbg_state
);

    state_t r_state;
    state_t w_next_state;
    owner_t r_owner;
    owner_t w_next_owner;

    logic w_last;
    logic w_decide;
    logic w_access;
    logic w_read_slot;
    logic w_write_slot;
    logic w_dma_allowed;

    logic [DATA_W-1:0] r_cpu_in;
    logic [DATA_W-1:0] r_dma_rdata;

    assign w_access = (r_state == S_ACCESS);
    assign w_decide = (r_state == S_IDLE) || (r_state == S_COMMIT);

    bus_arb_slot_timer #(
        .WAIT (WAIT)
    ) u_slot_timer (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_decide),
        .o_last (w_last)
    );

    // DMA handshake: dma_req is a level with address/we/wdata held stable until the
    // one-cycle dma_ack pulse; dma_req is only looked at in the decision cycle.
`ifdef ARB_DMA_BURST_EN
    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(DMA_BURST);

    logic [BURST_CNT_W-1:0] r_burst_cnt;

    assign w_dma_allowed = (r_owner == OWN_CPU) || (r_burst_cnt < BURST_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (w_decide) begin
            r_burst_cnt <= (w_next_owner == OWN_DMA) ? r_burst_cnt + BURST_CNT_W'(1) : '0;
        end
    end
`else
    assign w_dma_allowed = (r_owner == OWN_CPU);
`endif

    assign w_next_owner = (dma_req && w_dma_allowed) ? OWN_DMA : OWN_CPU;

    // Both rd and we set on the core side is treated as a write.
    assign w_write_slot = (r_owner == OWN_DMA) ? dma_we  : cpu_we;
    assign w_read_slot  = (r_owner == OWN_DMA) ? ~dma_we : (cpu_rd & ~cpu_we);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= OWN_CPU;
        end else begin
            r_state <= w_next_state;
            if (w_decide) begin
                r_owner <= w_next_owner;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_address  = '0;
        mem_wdata    = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        cpu_ce       = 1'b0;
        dma_ack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                mem_address = (r_owner == OWN_DMA) ? dma_address : cpu_address;
                mem_wdata   = (r_owner == OWN_DMA) ? dma_wdata   : cpu_out;
                mem_re      = w_read_slot;
                mem_we      = w_write_slot & w_last;
                if (w_last) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                cpu_ce       = (r_owner == OWN_CPU);
                dma_ack      = (r_owner == OWN_DMA);
                w_next_state = S_ACCESS;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cpu_in    <= '0;
            r_dma_rdata <= '0;
        end else if (w_access && w_last && w_read_slot) begin
            if (r_owner == OWN_DMA) begin
                r_dma_rdata <= mem_rdata;
            end else begin
                r_cpu_in <= mem_rdata;
            end
        end
    end

    assign cpu_in      = r_cpu_in;
    assign dma_rdata   = r_dma_rdata;
    assign grant_dma   = (r_owner == OWN_DMA);
    assign o_dbg_state = r_state;

endmodule
